koordinat_bolge_izleyici: RTL and testbench

KOORDINAT_BOLGE_IZLEYICI -- requirements
Module: koordinat_bolge_izleyici

---
 rtl/koordinat_bolge_izleyici.sv | 122 ++++++++++++
 tb/tb_koordinat_bolge_izleyici.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/koordinat_bolge_izleyici.sv
// ============================================================================
// Module  : koordinat_bolge_izleyici
// Brief   : Merges message fields into an (x,y) point, classifies it into one
//           of four regions behind a one-entry output register, and keeps
//           saturating per-region hit counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module koordinat_bolge_izleyici #(
  parameter int ALAN_W  = 4,
  parameter int ESIK    = 2**(ALAN_W-1)-1,
  parameter int SAYAC_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mesaj_gecerli,
  input  logic [4*ALAN_W-1:0]    mesaj,
  output logic                   mesaj_hazir,
  input  logic                   birlestirme_modu,
  input  logic                   sayac_temizle,
  output logic                   bolge_gecerli,
  output logic [1:0]             bolge,
  input  logic                   bolge_hazir,
  output logic [4*SAYAC_W-1:0]   sayaclar
);

  typedef enum logic [0:0] {
    BOS  = 1'b0,
    DOLU = 1'b1
  } durum_t;

  localparam logic [ALAN_W:0]    ESIK_V    = ESIK[ALAN_W:0];
  localparam logic [SAYAC_W-1:0] SAYAC_MAX = '1;

  durum_t              durum_q, durum_d;
  logic [1:0]          bolge_q, bolge_d;
  logic [SAYAC_W-1:0]  sayac_q [4];
  logic [SAYAC_W-1:0]  sayac_d [4];

  logic                kabul;
  logic [ALAN_W-1:0]   x_w, y_w;
  logic                x_yuksek, y_yuksek;
  logic [1:0]          bolge_yeni;

  function automatic logic [ALAN_W-1:0] birlestir(
    input logic [ALAN_W-1:0] a,
    input logic [ALAN_W-1:0] b,
    input logic              maks
  );
    if (maks) return (a > b) ? a : b;
    else      return a | b;
  endfunction

  assign x_w = birlestir(mesaj[3*ALAN_W-1:2*ALAN_W], mesaj[2*ALAN_W-1:ALAN_W], birlestirme_modu);
  assign y_w = birlestir(mesaj[4*ALAN_W-1:3*ALAN_W], mesaj[ALAN_W-1:0], birlestirme_modu);

  assign x_yuksek = {1'b0, x_w} > ESIK_V;
  assign y_yuksek = {1'b0, y_w} > ESIK_V;

  always_comb begin
    bolge_yeni = 2'b01;
    case ({y_yuksek, x_yuksek})
      2'b11:   bolge_yeni = 2'b11;
      2'b10:   bolge_yeni = 2'b00;
      2'b01:   bolge_yeni = 2'b10;
      default: bolge_yeni = 2'b01;
    endcase
  end

  assign bolge_gecerli = (durum_q == DOLU);
  assign bolge         = bolge_q;
  assign mesaj_hazir   = !bolge_gecerli || bolge_hazir;
  assign kabul         = mesaj_gecerli && mesaj_hazir;

  always_comb begin
    durum_d = durum_q;
    bolge_d = bolge_q;
    case (durum_q)
      BOS: begin
        if (kabul) durum_d = DOLU;
      end
      DOLU: begin
        if (kabul)            durum_d = DOLU;
        else if (bolge_hazir) durum_d = BOS;
      end
      default: durum_d = BOS;
    endcase
    if (kabul) bolge_d = bolge_yeni;
  end

  // Clear has priority over counting a message accepted on the same edge.
  always_comb begin
    for (int k = 0; k < 4; k++) sayac_d[k] = sayac_q[k];
    if (sayac_temizle) begin
      for (int k = 0; k < 4; k++) sayac_d[k] = '0;
    end else if (kabul && (sayac_q[bolge_yeni] != SAYAC_MAX)) begin
      sayac_d[bolge_yeni] = sayac_q[bolge_yeni] + SAYAC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q <= BOS;
      bolge_q <= 2'b00;
      for (int k = 0; k < 4; k++) sayac_q[k] <= '0;
    end else begin
      durum_q <= durum_d;
      bolge_q <= bolge_d;
      for (int k = 0; k < 4; k++) sayac_q[k] <= sayac_d[k];
    end
  end

  generate
    for (genvar k = 0; k < 4; k++) begin : g_sayac_paket
      assign sayaclar[k*SAYAC_W +: SAYAC_W] = sayac_q[k];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_koordinat_bolge_izleyici.sv
// ============================================================================
// Module  : tb_koordinat_bolge_izleyici
// Brief   : Directed self-checking bench for koordinat_bolge_izleyici.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_koordinat_bolge_izleyici;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int test_sayisi = 0;
  int hata_sayisi = 0;

  // Default instance: ALAN_W=4, ESIK=7, SAYAC_W=8
  logic        a_mv, a_hazir, a_mod, a_temizle, a_bg, a_bh;
  logic [15:0] a_mesaj;
  logic [1:0]  a_bolge;
  logic [31:0] a_sayac;

  // ESIK=5 instance
  logic        e_mv, e_hazir, e_mod, e_temizle, e_bg, e_bh;
  logic [15:0] e_mesaj;
  logic [1:0]  e_bolge;
  logic [31:0] e_sayac;

  // SAYAC_W=2 instance
  logic        s_mv, s_hazir, s_mod, s_temizle, s_bg, s_bh;
  logic [15:0] s_mesaj;
  logic [1:0]  s_bolge;
  logic [7:0]  s_sayac;

  koordinat_bolge_izleyici u_dut (
    .clk(clk), .rst(rst), .mesaj_gecerli(a_mv), .mesaj(a_mesaj), .mesaj_hazir(a_hazir),
    .birlestirme_modu(a_mod), .sayac_temizle(a_temizle), .bolge_gecerli(a_bg),
    .bolge(a_bolge), .bolge_hazir(a_bh), .sayaclar(a_sayac)
  );

  koordinat_bolge_izleyici #(.ALAN_W(4), .ESIK(5), .SAYAC_W(8)) u_esik (
    .clk(clk), .rst(rst), .mesaj_gecerli(e_mv), .mesaj(e_mesaj), .mesaj_hazir(e_hazir),
    .birlestirme_modu(e_mod), .sayac_temizle(e_temizle), .bolge_gecerli(e_bg),
    .bolge(e_bolge), .bolge_hazir(e_bh), .sayaclar(e_sayac)
  );

  koordinat_bolge_izleyici #(.ALAN_W(4), .ESIK(7), .SAYAC_W(2)) u_sat (
    .clk(clk), .rst(rst), .mesaj_gecerli(s_mv), .mesaj(s_mesaj), .mesaj_hazir(s_hazir),
    .birlestirme_modu(s_mod), .sayac_temizle(s_temizle), .bolge_gecerli(s_bg),
    .bolge(s_bolge), .bolge_hazir(s_bh), .sayaclar(s_sayac)
  );

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    test_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: observed=%0h expected=%0h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic tik();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] akis_mesaj [4] = '{16'h8000, 16'h0880, 16'h1234, 16'h8808};
  logic [1:0]  akis_bolge [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

  initial begin
    rst = 1'b0;
    {a_mv, a_mod, a_temizle, a_bh} = '0; a_mesaj = '0;
    {e_mv, e_mod, e_temizle, e_bh} = '0; e_mesaj = '0;
    {s_mv, s_mod, s_temizle, s_bh} = '0; s_mesaj = '0;
    #1 rst = 1'b1;
    #1;
    kontrol("reset_gecerli", {31'd0, a_bg}, 32'd0);
    kontrol("reset_bolge", {30'd0, a_bolge}, 32'd0);
    kontrol("reset_sayac", a_sayac, 32'd0);
    kontrol("reset_hazir", {31'd0, a_hazir}, 32'd1);
    tik(); tik();
    rst = 1'b0;

    // Back-to-back stream, full throughput
    a_mv = 1'b1; a_bh = 1'b1; a_mod = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_mesaj = akis_mesaj[i];
      kontrol($sformatf("akis_hazir%0d", i), {31'd0, a_hazir}, 32'd1);
      tik();
      kontrol($sformatf("akis_gecerli%0d", i), {31'd0, a_bg}, 32'd1);
      kontrol($sformatf("akis_bolge%0d", i), {30'd0, a_bolge}, {30'd0, akis_bolge[i]});
    end
    a_mv = 1'b0;
    tik();
    kontrol("akis_bosalma", {31'd0, a_bg}, 32'd0);
    kontrol("akis_sayac", a_sayac, 32'h01010101);

    // Backpressure
    a_mv = 1'b1; a_bh = 1'b0; a_mesaj = 16'h8808;
    tik();
    kontrol("bp_ilk_bolge", {30'd0, a_bolge}, 32'd3);
    a_mesaj = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      kontrol($sformatf("bp_hazir%0d", i), {31'd0, a_hazir}, 32'd0);
      tik();
      kontrol($sformatf("bp_gecerli%0d", i), {31'd0, a_bg}, 32'd1);
      kontrol($sformatf("bp_bolge%0d", i), {30'd0, a_bolge}, 32'd3);
    end
    kontrol("bp_sayac", a_sayac, 32'h02010101);
    a_bh = 1'b1;
    #1 kontrol("bp_hazir_son", {31'd0, a_hazir}, 32'd1);
    tik();
    kontrol("bp_yeni_bolge", {30'd0, a_bolge}, 32'd1);
    kontrol("bp_yeni_sayac", a_sayac, 32'h02010201);
    a_mv = 1'b0;
    tik();

    // Clear coinciding with accept
    a_mv = 1'b1; a_mesaj = 16'h8000; a_temizle = 1'b1;
    tik();
    kontrol("temizle_sayac", a_sayac, 32'd0);
    kontrol("temizle_gecerli", {31'd0, a_bg}, 32'd1);
    kontrol("temizle_bolge", {30'd0, a_bolge}, 32'd0);
    a_temizle = 1'b0; a_mv = 1'b0;
    tik();

    // Asynchronous reset while holding a result
    a_mv = 1'b1; a_bh = 1'b0; a_mesaj = 16'h8808;
    tik();
    a_mv = 1'b0;
    kontrol("ars_oncesi_sayac", a_sayac, 32'h01000000);
    #2 rst = 1'b1;
    #1;
    kontrol("ars_gecerli", {31'd0, a_bg}, 32'd0);
    kontrol("ars_bolge", {30'd0, a_bolge}, 32'd0);
    kontrol("ars_sayac", a_sayac, 32'd0);
    tik();
    rst = 1'b0;
    #1 kontrol("ars_hazir", {31'd0, a_hazir}, 32'd1);
    a_mv = 1'b1; a_mesaj = 16'h0880;
    tik();
    kontrol("ars_sonra_bolge", {30'd0, a_bolge}, 32'd2);
    kontrol("ars_sonra_sayac", a_sayac, 32'h00010000);
    a_mv = 1'b0;

    // Threshold 5, OR vs max merge
    e_mv = 1'b1; e_bh = 1'b1; e_mesaj = 16'h3404; e_mod = 1'b0;
    tik();
    kontrol("esik_or_bolge", {30'd0, e_bolge}, 32'd0);
    e_mod = 1'b1;
    tik();
    kontrol("esik_max_bolge", {30'd0, e_bolge}, 32'd1);
    e_mv = 1'b0;
    tik();
    kontrol("esik_sayac", e_sayac, 32'h00000101);

    // Saturation with 2-bit counters
    s_mv = 1'b1; s_bh = 1'b1; s_mesaj = 16'h1234;
    for (int i = 1; i <= 5; i++) begin
      tik();
      kontrol($sformatf("doyma%0d", i), {24'd0, s_sayac},
              {24'd0, 8'(((i > 3) ? 3 : i) << 2)});
    end
    s_mv = 1'b0;
    tik();
    kontrol("doyma_kalici", {24'd0, s_sayac}, 32'h0000000C);

    $display("[TB] %0d tests run, %0d failed", test_sayisi, hata_sayisi);
    $finish;
  end

endmodule

`default_nettype wire
